// File: rtl/pipelined_ripple_carry_adder_pkg.sv
// Shared definitions for the pipelined ripple carry adder: operation encoding,
// slice width derivation and the parameter legality rule.
package pipelined_ripple_carry_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // WIDTH must split evenly into between 1 and WIDTH slices.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 32'sd1) && (stages <= width) && ((width % stages) == 32'sd0);
    endfunction

endpackage

// File: rtl/pipelined_ripple_carry_adder_rca.sv
// Combinational ripple chain of WIDTH full adders; also exposes the carry
// entering the top bit so the caller can derive signed overflow.
module rca_slice
    import pipelined_ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic carry_s;

    // Full-adder ripple from bit 0 upwards.
    always_comb begin
        carry_s  = cin;
        sum      = {WIDTH{1'b0}};
        c_msb_in = 1'b0;
        for (int i = 32'sd0; i < WIDTH; i++) begin
            c_msb_in = carry_s;
            sum[i]   = a[i] ^ b[i] ^ carry_s;
            carry_s  = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
        end
        cout = carry_s;
    end

endmodule

// File: rtl/pipelined_ripple_carry_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple slices, one slice per
// pipeline stage, with valid/ready flow control and bubble collapsing.
module pipelined_ripple_carry_adder
    import pipelined_ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SLICE_W = slice_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_ripple_carry_adder: WIDTH must be a multiple of STAGES (1..WIDTH)");
    end

    logic [STAGES-1:0]              v_r;
    logic [STAGES-1:0]              c_r;
    logic [STAGES-1:0][WIDTH-1:0]   sum_r;
    logic [STAGES-1:0][WIDTH-1:0]   a_r;
    logic [STAGES-1:0][WIDTH-1:0]   b_r;
    logic                           ovf_r;

    logic [STAGES-1:0]              en_s;
    logic                           en_chain_s;
    logic [STAGES-1:0]              src_v_s;
    logic [STAGES-1:0]              cin_src_s;
    logic [STAGES-1:0]              cout_s;
    logic [STAGES-1:0]              c_msb_s;
    logic [STAGES-1:0][WIDTH-1:0]   a_src_s;
    logic [STAGES-1:0][WIDTH-1:0]   b_src_s;
    logic [STAGES-1:0][WIDTH-1:0]   sum_nxt_s;
    logic [STAGES-1:0][SLICE_W-1:0] slice_sum_s;
    logic [WIDTH-1:0]               b_in_s;
    logic                           cin_in_s;
    logic                           unused_s;

    // Subtraction is A + ~B + 1, so the caller's carry-in is dropped.
    always_comb begin
        if (in_sub == OP_SUB) begin
            b_in_s   = ~in_b;
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = in_b;
            cin_in_s = in_cin;
        end
    end

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        en_s       = {STAGES{1'b0}};
        en_chain_s = out_ready;
        for (int k = STAGES - 32'sd1; k >= 32'sd0; k--) begin
            if (v_r[k]) begin
                en_chain_s = en_chain_s;
            end else begin
                en_chain_s = 1'b1;
            end
            en_s[k] = en_chain_s;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_v_s[k]   = in_valid;
            assign a_src_s[k]   = in_a;
            assign b_src_s[k]   = b_in_s;
            assign cin_src_s[k] = cin_in_s;
            assign sum_nxt_s[k] = WIDTH'(slice_sum_s[k]);
        end else begin : g_next
            assign src_v_s[k]   = v_r[k-1];
            assign a_src_s[k]   = a_r[k-1];
            assign b_src_s[k]   = b_r[k-1];
            assign cin_src_s[k] = c_r[k-1];
            assign sum_nxt_s[k] = sum_r[k-1] | (WIDTH'(slice_sum_s[k]) << (SLICE_W * k));
        end

        rca_slice #(
            .WIDTH(SLICE_W)
        ) u_slice (
            .a        (a_src_s[k][SLICE_W*k +: SLICE_W]),
            .b        (b_src_s[k][SLICE_W*k +: SLICE_W]),
            .cin      (cin_src_s[k]),
            .sum      (slice_sum_s[k]),
            .cout     (cout_s[k]),
            .c_msb_in (c_msb_s[k])
        );
    end

    // Stage registers: load from upstream when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= {STAGES{1'b0}};
            c_r   <= {STAGES{1'b0}};
            sum_r <= {(STAGES*WIDTH){1'b0}};
            a_r   <= {(STAGES*WIDTH){1'b0}};
            b_r   <= {(STAGES*WIDTH){1'b0}};
            ovf_r <= 1'b0;
        end else begin
            for (int k = 32'sd0; k < STAGES; k++) begin
                if (en_s[k]) begin
                    v_r[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        sum_r[k] <= sum_nxt_s[k];
                        c_r[k]   <= cout_s[k];
                        a_r[k]   <= a_src_s[k];
                        b_r[k]   <= b_src_s[k];
                    end
                end
            end
            if (en_s[STAGES-1] && src_v_s[STAGES-1]) begin
                ovf_r <= c_msb_s[STAGES-1] ^ cout_s[STAGES-1];
            end
        end
    end

    assign in_ready  = en_s[0];
    assign out_valid = v_r[STAGES-1];
    assign out_sum   = sum_r[STAGES-1];
    assign out_cout  = c_r[STAGES-1];
    assign out_ovf   = ovf_r;

    // Consumed low operand slices and the last stage's operands are dead bits.
    assign unused_s = ^{a_r, b_r, c_msb_s};

endmodule

// File: tb/tb_pipelined_ripple_carry_adder.sv
// Self-checking bench: directed vectors, backpressure, throughput, reset
// mid-flight and a randomized scoreboard against an arithmetic reference.
module tb_pipelined_ripple_carry_adder;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    res_t        exp_q[$];
    logic [63:0] pop_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          accept_cycle = 0;
    int          pop_cycle = 0;
    int          pops = 0;
    bit          acc_flag = 1'b0;
    bit          held_v = 1'b0;
    res_t        held_res;
    res_t        last_res;

    pipelined_ripple_carry_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned result modulo 2^64, carry as unsigned carry / no-borrow,
    // overflow as the exact signed result falling outside the 64-bit range.
    function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input logic sub);
        res_t        r;
        logic [64:0] ua;
        logic [65:0] sa;
        logic [65:0] sb;
        logic [65:0] sres;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            sres   = sa - sb;
        end else begin
            ua     = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            r.sum  = ua[63:0];
            r.cout = ua[64];
            sres   = sa + sb + {65'd0, cin};
        end
        r.ovf = (sres[65:63] != 3'b000) && (sres[65:63] != 3'b111);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, input logic valid);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = valid;
    endtask

    // One clock: observe handshakes at the falling edge, then move past the rising edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        cycle++;
        acc_flag = 1'b0;
        if (held_v) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sum", out_sum, held_res.sum);
            check("hold_flags", 64'({out_cout, out_ovf}), 64'({held_res.cout, held_res.ovf}));
        end
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_beat: observed sum 0x%0h expected no beat", out_sum);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sum", out_sum, e.sum);
                check("cout_ovf", 64'({out_cout, out_ovf}), 64'({e.cout, e.ovf}));
            end
            last_res  = {out_sum, out_cout, out_ovf};
            pop_cycle = cycle;
            pops++;
            pop_log.push_back(out_sum);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_a, in_b, in_cin, in_sub));
            accept_cycle = cycle;
            acc_flag     = 1'b1;
        end
        held_v   = out_valid && !out_ready;
        held_res = {out_sum, out_cout, out_ovf};
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [63:0] es,
                          input logic ec, input logic eo);
        int a0;
        int p0;
        int n;
        out_ready = 1'b1;
        drive(a, b, cin, sub, 1'b1);
        p0 = pops;
        step();
        check({tag, "_accept"}, 64'(acc_flag), 64'd1);
        a0 = accept_cycle;
        in_valid = 1'b0;
        n = 0;
        while (pops == p0 && n < 12) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(pop_cycle - a0), 64'd4);
        check({tag, "_sum"}, last_res.sum, es);
        check({tag, "_flags"}, 64'({last_res.cout, last_res.ovf}), 64'({ec, eo}));
    endtask

    initial begin
        int i;
        int t;
        int n_acc;
        int guard;
        int p0;

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_flags", 64'({out_cout, out_ovf}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        single("basic", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
        single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        single("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        single("sub", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        // Backpressure: 8 beats, consumer stalled for cycles 3..10.
        pop_log.delete();
        i = 0;
        t = 0;
        while ((i < 8 || exp_q.size() != 0) && t < 60) begin
            out_ready = !(t >= 3 && t <= 10);
            drive(64'(i), 64'(i), 1'b0, 1'b0, i < 8);
            if (t == 9) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_accepted", 64'(i), 64'd4);
            end
            step();
            if (acc_flag) i++;
            t++;
        end
        check("bp_count", 64'(pop_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < pop_log.size(); k++) begin
            check("bp_order", pop_log[k], 64'(2 * k));
        end

        // Throughput: one beat per cycle after the fill.
        out_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 20; k++) begin
            drive({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
            step();
            check("tp_accept", 64'(acc_flag), 64'd1);
        end
        check("tp_pops", 64'(pops - p0), 64'd16);
        drain(20);

        // Random traffic with random backpressure.
        n_acc = 0;
        guard = 0;
        in_valid = 1'b0;
        while (n_acc < 1000 && guard < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                drive({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1);
                if ($urandom_range(0, 7) == 0) in_a = 64'hFFFF_FFFF_FFFF_FFFF;
                if ($urandom_range(0, 7) == 0) in_b = 64'h8000_0000_0000_0000;
            end
            step();
            if (acc_flag) begin
                n_acc++;
                in_valid = 1'b0;
            end
            guard++;
        end
        check("rand_beats", 64'(n_acc), 64'd1000);
        drain(40);

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(64'(k * 17), 64'(k * 3), 1'b0, 1'b0, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_valid_before", 64'(out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_out_sum", out_sum, 64'd0);
        check("mid_flags", 64'({out_cout, out_ovf}), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        held_v = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        single("post_rst", 64'd100, 64'd23, 1'b1, 1'b0, 64'd124, 1'b0, 1'b0);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
